// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline types for the RV32I core; hazard_ctrl uses the memory-wait FSM state.
package rv32i_types;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } hc_state_t;

   localparam logic [4:0] REG_X0 = 5'd0;

   // x0 is hardwired to zero, so a load targeting it never creates a dependency.
   function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
      return (rd != REG_X0) && (rd == rs);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline control bundle between the core datapath (master) and hazard_ctrl (slave).
interface hazard_ctrl_if;

   logic        imem_pending;
   logic        imem_resp;
   logic        dmem_pending;
   logic        dmem_resp;
   logic [4:0]  id_rs1_s;
   logic [4:0]  id_rs2_s;
   logic [4:0]  ex_rd_s;
   logic        ex_mem_re;
   logic        ex_valid;
   logic        flush_req;

   logic        if_en;
   logic        id_en;
   logic        ex_en;
   logic        mem_en;
   logic        wb_en;
   logic        id_ex_bubble;
   logic        if_id_flush;
   logic [31:0] stall_cnt;
   logic [31:0] lu_cnt;

   modport master (
      output imem_pending, imem_resp, dmem_pending, dmem_resp,
             id_rs1_s, id_rs2_s, ex_rd_s, ex_mem_re, ex_valid, flush_req,
      input  if_en, id_en, ex_en, mem_en, wb_en, id_ex_bubble, if_id_flush,
             stall_cnt, lu_cnt
   );

   modport slave (
      input  imem_pending, imem_resp, dmem_pending, dmem_resp,
             id_rs1_s, id_rs2_s, ex_rd_s, ex_mem_re, ex_valid, flush_req,
      output if_en, id_en, ex_en, mem_en, wb_en, id_ex_bubble, if_id_flush,
             stall_cnt, lu_cnt
   );

endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: freezes the pipe on outstanding memory, inserts load-use
// bubbles, and applies branch flushes (deferred until the pipe can move again).
module hazard_ctrl
   import rv32i_types::*;
(
   input logic        clk,
   input logic        rst,
   hazard_ctrl_if.slave hc
);

   hc_state_t state;
   logic      imem_done;
   logic      dmem_done;
   logic      flush_pend;

   logic i_ok;
   logic d_ok;
   logic advance;
   logic load_use;
   logic flush;
   logic any_stall;

   // Sticky done flags remember a response that arrived while the other side was still busy.
   assign i_ok    = ~hc.imem_pending | hc.imem_resp | imem_done;
   assign d_ok    = ~hc.dmem_pending | hc.dmem_resp | dmem_done;
   assign advance = i_ok & d_ok;

   assign load_use = hc.ex_valid & hc.ex_mem_re &
                     (reg_match(hc.ex_rd_s, hc.id_rs1_s) | reg_match(hc.ex_rd_s, hc.id_rs2_s));
   assign flush    = hc.flush_req | flush_pend;

   always_comb begin
      hc.if_en        = 1'b0;
      hc.id_en        = 1'b0;
      hc.ex_en        = 1'b0;
      hc.mem_en       = 1'b0;
      hc.wb_en        = 1'b0;
      hc.id_ex_bubble = 1'b0;
      hc.if_id_flush  = 1'b0;
      if (!rst && advance) begin
         hc.ex_en  = 1'b1;
         hc.mem_en = 1'b1;
         hc.wb_en  = 1'b1;
         // A flush squashes the dependent instruction anyway, so it wins over the bubble.
         if (flush) begin
            hc.if_en       = 1'b1;
            hc.id_en       = 1'b1;
            hc.if_id_flush = 1'b1;
         end else if (load_use) begin
            hc.id_ex_bubble = 1'b1;
         end else begin
            hc.if_en = 1'b1;
            hc.id_en = 1'b1;
         end
      end
   end

   assign any_stall = ~(hc.if_en & hc.id_en & hc.ex_en & hc.mem_en & hc.wb_en);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= RUN;
         imem_done    <= 1'b0;
         dmem_done    <= 1'b0;
         flush_pend   <= 1'b0;
         hc.stall_cnt <= '0;
         hc.lu_cnt    <= '0;
      end else begin
         case (state)
            RUN: begin
               if (!advance) begin
                  state     <= MEM_WAIT;
                  imem_done <= hc.imem_resp;
                  dmem_done <= hc.dmem_resp;
               end else begin
                  imem_done <= 1'b0;
                  dmem_done <= 1'b0;
               end
            end
            MEM_WAIT: begin
               if (advance) begin
                  state     <= RUN;
                  imem_done <= 1'b0;
                  dmem_done <= 1'b0;
               end else begin
                  imem_done <= imem_done | hc.imem_resp;
                  dmem_done <= dmem_done | hc.dmem_resp;
               end
            end
            default: begin
               state     <= RUN;
               imem_done <= 1'b0;
               dmem_done <= 1'b0;
            end
         endcase

         if (advance) begin
            flush_pend <= 1'b0;
         end else if (hc.flush_req) begin
            flush_pend <= 1'b1;
         end

         if (any_stall) begin
            hc.stall_cnt <= hc.stall_cnt + 32'd1;
         end
         if (hc.id_ex_bubble) begin
            hc.lu_cnt <= hc.lu_cnt + 32'd1;
         end
      end
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports clk in 1 (sole clock, rising edge) and rst in 1 (reset is synchronous and active-high).
REQ-002 SHALL have ports imem_pending in 1 (IF fetch outstanding, held until its resp) and imem_resp in 1 (fetch done, 1-cycle pulse).
REQ-003 SHALL have ports dmem_pending in 1 (MEM access outstanding, held until its resp) and dmem_resp in 1 (access done, 1-cycle pulse).
REQ-004 SHALL have ports id_rs1_s, id_rs2_s in 5 (ID source regs); ex_rd_s in 5, ex_mem_re in 1, ex_valid in 1 (EX instr dest, is-load, valid).
REQ-005 SHALL have port flush_req in 1 (EX redirect: taken branch or jump).
REQ-006 SHALL have outputs if_en, id_en, ex_en, mem_en, wb_en, each 1 (stage-register load enables).
REQ-007 SHALL have outputs id_ex_bubble out 1 (load invalid into ID/EX) and if_id_flush out 1 (clear valid_s of IF/ID and ID/EX).
REQ-008 SHALL have outputs stall_cnt out 32 and lu_cnt out 32 (performance counters).

Function
REQ-009 SHALL implement FSM states RUN and MEM_WAIT plus sticky flags imem_done, dmem_done and flush_pend.
REQ-010 SHALL define i_ok = ~imem_pending | imem_resp | imem_done, d_ok = ~dmem_pending | dmem_resp | dmem_done, and advance = i_ok & d_ok.
REQ-011 In RUN, advance=0: next state MEM_WAIT; imem_done <= imem_resp; dmem_done <= dmem_resp.
REQ-012 In MEM_WAIT: imem_done |= imem_resp, dmem_done |= dmem_resp; advance=1 returns to RUN and clears both flags the same edge.
REQ-013 advance=0: all five enables 0, id_ex_bubble 0, if_id_flush 0; no stage register changes.
REQ-014 load_use = ex_valid & ex_mem_re & (ex_rd_s != 0) & (ex_rd_s == id_rs1_s | ex_rd_s == id_rs2_s).
REQ-015 advance=1, load_use=1, no flush: if_en=id_en=0, id_ex_bubble=1, ex_en=mem_en=wb_en=1 (exactly one bubble per hazard).
REQ-016 advance=1, no hazard, no flush: all enables 1, id_ex_bubble 0.
REQ-017 flush = flush_req | flush_pend; advance=1 with flush: all enables 1, if_id_flush 1, id_ex_bubble 0 (flush beats load-use).
REQ-018 flush_req while advance=0 SHALL set flush_pend; flush_pend clears on the next advance cycle.
REQ-019 stall_cnt SHALL increment each cycle with any enable low; lu_cnt each load-use bubble cycle; both wrap at 2^32.
REQ-020 imem_resp and dmem_resp in the same cycle SHALL both count; the later one triggers advance.

Reset
REQ-021 rst SHALL force state RUN, imem_done, dmem_done, flush_pend 0 and both counters 0 on the clock edge.
REQ-022 While rst=1 all enables, id_ex_bubble and if_id_flush SHALL be 0, including reset asserted mid-MEM_WAIT.

Structure
REQ-023 SHALL declare the hc_state_t enum {RUN, MEM_WAIT} in rv32i_types.
REQ-024 SHALL be one flat module; enables are combinational from state, flags and inputs; no sub-module.

Verification
REQ-025 imem_pending=1, resp after 3 cycles, dmem idle -> enables 0 for 3 cycles, 1 on resp cycle; stall_cnt=3.
REQ-026 imem_resp cycle 2, dmem_resp cycle 5, both pending from cycle 0 -> advance only at cycle 5; imem_done set cycles 3-5.
REQ-027 EX lw x5, ID add x6,x5,x1 -> one cycle if_en=id_en=0, id_ex_bubble=1, lu_cnt=1; next cycle all enables 1.
REQ-028 EX lw x0, ID reads x0 -> no bubble; lu_cnt stays 0.
REQ-029 flush_req pulse during MEM_WAIT -> if_id_flush=1 only on the advance cycle, then flush_pend=0.
REQ-030 load_use and flush_req together -> if_id_flush=1, id_ex_bubble=0; rst mid-MEM_WAIT -> next cycle RUN, counters 0.
